// File: rtl/ak4619_target.sv
// TDM128 CODEC stand-in: receives four DAC slots on sdin1 and returns four ADC slots on sdout1.
// Each slot spans 32 BICK periods; only the top W bit positions of a slot carry data.
module ak4619_target #(
    parameter int W = 16
) (
    input  logic                clk_256fs,
    input  logic                rst,
    input  logic                pdn,
    input  logic                bick,
    input  logic                lrck,
    input  logic                sdin1,
    output logic                sdout1,
    input  logic signed [W-1:0] adc_in0,
    input  logic signed [W-1:0] adc_in1,
    input  logic signed [W-1:0] adc_in2,
    input  logic signed [W-1:0] adc_in3,
    output logic signed [W-1:0] dac_out0,
    output logic signed [W-1:0] dac_out1,
    output logic signed [W-1:0] dac_out2,
    output logic signed [W-1:0] dac_out3,
    output logic                frame_valid,
    output logic                sync_err,
    output logic                locked
);
    typedef enum logic {SYNC_WAIT = 1'b0, RUN = 1'b1} state_t;

    localparam logic [W-1:0] L_MSB = ~({W{1'b1}} >> 1);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_lrck_q;
    logic         r_sdout;
    logic         r_fv;
    logic         r_se;
    logic         r_locked;
    logic [6:0]   r_bitpos;
    logic [W-1:0] r_tx [4];
    logic [W-1:0] r_rx [4];
    logic [W-1:0] r_dac [4];

    logic         w_clr;
    logic         w_fs_start;
    logic [6:0]   w_pos;
    logic [W-1:0] w_tx_word;
    logic [W-1:0] w_tx_shift;
    logic [W-1:0] w_rx_mask;
    logic         w_tx_bit;

    assign w_clr      = rst | ~pdn;
    assign w_fs_start = r_lrck_q & ~lrck;
    assign w_pos      = w_fs_start ? 7'd0 : r_bitpos;
    // Slot 0 bit 0 goes out in the same cycle the ADC words are captured.
    assign w_tx_word  = w_fs_start ? adc_in0 : r_tx[w_pos[6:5]];
    // Shifting past W leaves zeros, so unused slot positions drive 0 and receive nothing.
    assign w_tx_shift = w_tx_word << w_pos[4:0];
    assign w_tx_bit   = w_tx_shift[W-1];
    assign w_rx_mask  = L_MSB >> r_bitpos[4:0];

    always_ff @(posedge clk_256fs) begin
        if (w_clr) r_state <= SYNC_WAIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_fs_start) w_state_nxt = RUN;
    end

    always_ff @(posedge clk_256fs) begin
        if (w_clr) begin
            r_lrck_q <= 1'b0;
            r_sdout  <= 1'b0;
            r_fv     <= 1'b0;
            r_se     <= 1'b0;
            r_locked <= 1'b0;
            r_bitpos <= 7'd0;
            for (int c = 0; c < 4; c++) begin
                r_tx[c]  <= '0;
                r_rx[c]  <= '0;
                r_dac[c] <= '0;
            end
        end else begin
            r_lrck_q <= lrck;
            r_fv     <= 1'b0;
            r_se     <= 1'b0;
            if (w_fs_start) begin
                r_locked <= 1'b1;
                r_bitpos <= 7'd0;
                r_tx[0]  <= adc_in0;
                r_tx[1]  <= adc_in1;
                r_tx[2]  <= adc_in2;
                r_tx[3]  <= adc_in3;
                for (int c = 0; c < 4; c++) r_rx[c] <= '0;
                // The very first boundary only locks; it has no completed frame behind it.
                if (r_state == RUN) begin
                    if (r_bitpos == 7'd0) begin
                        for (int c = 0; c < 4; c++) r_dac[c] <= r_rx[c];
                        r_fv <= 1'b1;
                    end else begin
                        r_se <= 1'b1;
                    end
                end
                if (!bick) r_sdout <= w_tx_bit;
            end else if (r_state == RUN) begin
                if (!bick) begin
                    r_sdout <= w_tx_bit;
                end else begin
                    r_rx[r_bitpos[6:5]] <= (r_rx[r_bitpos[6:5]] & ~w_rx_mask)
                                         | ({W{sdin1}} & w_rx_mask);
                    r_bitpos <= r_bitpos + 7'd1;
                end
            end else begin
                r_sdout <= 1'b0;
            end
        end
    end

    assign sdout1      = r_sdout;
    assign dac_out0    = r_dac[0];
    assign dac_out1    = r_dac[1];
    assign dac_out2    = r_dac[2];
    assign dac_out3    = r_dac[3];
    assign frame_valid = r_fv;
    assign sync_err    = r_se;
    assign locked      = r_locked;

endmodule

// File: tb/tb_ak4619_target.sv
// Bench for ak4619_target: the bench plays the CODEC driver for a W=16 and a W=24 target
// side by side and checks them against a frame-level model of the TDM128 link.
module tb_ak4619_target;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pdn, bick, lrck;
    logic        sdin [2];
    logic        so [2];
    logic        fv [2];
    logic        se [2];
    logic        lk [2];
    logic [31:0] adc [4];
    logic [15:0] dac16 [4];
    logic [23:0] dac24 [4];

    logic [31:0] txw [4];
    logic [31:0] m_last [4];
    logic [31:0] m_dac [4];
    bit          m_armed;
    bit          m_locked;
    int          m_prev_len;
    int          n_chk = 0;
    int          n_pass = 0;

    ak4619_target #(.W(16)) u_w16 (
        .clk_256fs(clk), .rst(rst), .pdn(pdn), .bick(bick), .lrck(lrck),
        .sdin1(sdin[0]), .sdout1(so[0]),
        .adc_in0(adc[0][15:0]), .adc_in1(adc[1][15:0]),
        .adc_in2(adc[2][15:0]), .adc_in3(adc[3][15:0]),
        .dac_out0(dac16[0]), .dac_out1(dac16[1]), .dac_out2(dac16[2]), .dac_out3(dac16[3]),
        .frame_valid(fv[0]), .sync_err(se[0]), .locked(lk[0])
    );

    ak4619_target #(.W(24)) u_w24 (
        .clk_256fs(clk), .rst(rst), .pdn(pdn), .bick(bick), .lrck(lrck),
        .sdin1(sdin[1]), .sdout1(so[1]),
        .adc_in0(adc[0][23:0]), .adc_in1(adc[1][23:0]),
        .adc_in2(adc[2][23:0]), .adc_in3(adc[3][23:0]),
        .dac_out0(dac24[0]), .dac_out1(dac24[1]), .dac_out2(dac24[2]), .dac_out3(dac24[3]),
        .frame_valid(fv[1]), .sync_err(se[1]), .locked(lk[1])
    );

    function automatic int wk(int k);
        return (k == 1) ? 24 : 16;
    endfunction

    function automatic logic [31:0] msk(int k);
        return (k == 1) ? 32'h00FF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] dac_of(int k, int c);
        return (k == 1) ? 32'(dac24[c]) : 32'(dac16[c]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic rand_words();
        for (int c = 0; c < 4; c++) begin
            txw[c] = $urandom;
            adc[c] = $urandom;
        end
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_w%0d_sdout", tag, wk(k)), 32'(so[k]), 32'd0);
            chk($sformatf("%s_w%0d_locked", tag, wk(k)), 32'(lk[k]), 32'd0);
            chk($sformatf("%s_w%0d_fv", tag, wk(k)), 32'(fv[k]), 32'd0);
            chk($sformatf("%s_w%0d_dac0", tag, wk(k)), dac_of(k, 0), 32'd0);
        end
    endtask

    // One LRCK period of len cycles; lrck falls at i=0 of the next call. drop<0: no power-down.
    task automatic frame(input string tag, input int len, input logic fill, input int drop);
        logic [31:0] cap [2][4];
        logic        unused [2];
        logic        stray [2];
        bit          full_tx;
        int          exp_fv, exp_se, p, b, c;
        full_tx = 1'b0;
        exp_fv  = 0;
        exp_se  = 0;
        for (int k = 0; k < 2; k++) begin
            unused[k] = 1'b0;
            stray[k]  = 1'b0;
            for (int j = 0; j < 4; j++) cap[k][j] = 32'd0;
        end
        for (int i = 0; i < len; i++) begin
            bick = (i % 2) == 1;
            lrck = (i >= len / 2);
            pdn  = !(drop >= 0 && i >= drop);
            p = i / 2;
            b = p % 32;
            c = p / 32;
            for (int k = 0; k < 2; k++)
                sdin[k] = (b < wk(k)) ? 1'(txw[c] >> (wk(k) - 1 - b)) : fill;
            @(posedge clk);
            #1;
            if (i == 0) begin
                if (m_armed) begin
                    if (m_locked) begin
                        if (m_prev_len == 256) begin
                            exp_fv = 1;
                            for (int j = 0; j < 4; j++) m_dac[j] = m_last[j];
                        end else begin
                            exp_se = 1;
                        end
                    end
                    m_locked = 1'b1;
                end
                full_tx = m_locked && drop < 0 && len == 256;
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("%s_w%0d_fv", tag, wk(k)), 32'(fv[k]), 32'(exp_fv));
                    chk($sformatf("%s_w%0d_syncerr", tag, wk(k)), 32'(se[k]), 32'(exp_se));
                    chk($sformatf("%s_w%0d_locked", tag, wk(k)), 32'(lk[k]), 32'(m_locked));
                    for (int j = 0; j < 4; j++)
                        chk($sformatf("%s_w%0d_dac%0d", tag, wk(k), j), dac_of(k, j),
                            m_dac[j] & msk(k));
                end
            end else begin
                for (int k = 0; k < 2; k++) stray[k] = stray[k] | fv[k] | se[k];
            end
            if (drop >= 0 && i == drop) begin
                m_locked = 1'b0;
                for (int j = 0; j < 4; j++) m_dac[j] = 32'd0;
                check_idle({tag, "_pdn"});
            end
            if (i % 2 == 0) begin
                for (int k = 0; k < 2; k++) begin
                    if (b < wk(k)) cap[k][c] = {cap[k][c][30:0], so[k]};
                    else unused[k] = unused[k] | so[k];
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_w%0d_stray_strobe", tag, wk(k)), 32'(stray[k]), 32'd0);
            if (full_tx) begin
                chk($sformatf("%s_w%0d_sdout_unused", tag, wk(k)), 32'(unused[k]), 32'd0);
                for (int j = 0; j < 4; j++)
                    chk($sformatf("%s_w%0d_sdout%0d", tag, wk(k), j), cap[k][j],
                        adc[j] & msk(k));
            end
        end
        m_prev_len = (drop >= 0) ? 0 : len;
        m_armed    = (drop < 0);
        for (int j = 0; j < 4; j++) m_last[j] = txw[j];
    endtask

    initial begin
        rst  = 1'b1;
        pdn  = 1'b1;
        bick = 1'b0;
        lrck = 1'b0;
        for (int k = 0; k < 2; k++) sdin[k] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            adc[c]    = 32'd0;
            txw[c]    = 32'd0;
            m_last[c] = 32'd0;
            m_dac[c]  = 32'd0;
        end
        for (int i = 0; i < 4; i++) begin
            bick = (i % 2) == 1;
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        check_idle("reset");

        // Clocks running but no LRCK fall yet: must stay unlocked.
        for (int i = 0; i < 32; i++) begin
            bick = (i % 2) == 1;
            lrck = (i >= 16);
            @(posedge clk);
            #1;
        end
        check_idle("prelock");
        m_armed    = 1'b1;
        m_locked   = 1'b0;
        m_prev_len = 0;

        txw = '{32'h1234, 32'h8001, 32'h7FFF, 32'hFFFF};
        adc = '{32'h0F0F, 32'hA5A5, 32'h0001, 32'h8000};
        frame("lock", 256, 1'b0, -1);
        frame("loop", 256, 1'b0, -1);

        rand_words();
        txw = '{32'd0, 32'd0, 32'd0, 32'd0};
        frame("unused_fill", 256, 1'b1, -1);
        rand_words();
        frame("rand_a", 256, 1'b0, -1);
        rand_words();
        frame("short", 200, 1'b0, -1);
        rand_words();
        txw = '{32'h5555, 32'h5555, 32'h5555, 32'h5555};
        frame("after_short", 256, 1'b0, -1);
        rand_words();
        frame("pdn_drop", 256, 1'b0, 138);
        rand_words();
        frame("pdn_up", 256, 1'b0, -1);
        rand_words();
        frame("relock", 256, 1'b0, -1);
        rand_words();
        frame("first_after_relock", 256, 1'b0, -1);

        rand_words();
        txw[0] = 32'h0080_0001;
        txw[3] = 32'h007F_FFFE;
        frame("edge24", 256, 1'b0, -1);
        for (int r = 0; r < 4; r++) begin
            rand_words();
            frame($sformatf("rand_b%0d", r), 256, $urandom_range(0, 1) == 1, -1);
        end
        rand_words();
        frame("final", 256, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
